// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: request bundle, FSM states, one-hot helper.
package dmem_arbiter_pkg;

  typedef logic [31:0] u32_t;
  typedef logic [3:0]  wrstb_t;

  localparam int DMEM_AW = 10;

  typedef struct packed {
    u32_t   addr;
    u32_t   wrdata;
    wrstb_t wrstb;
  } mem_req_t;

  typedef enum logic {ARB_IDLE, ARB_RESP} arb_state_t;

  // Index of the set bit in a one-hot vector of up to four requesters.
  function automatic int onehot_idx(input logic [3:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Combinational one-hot picker: first valid port found scanning upward from rr_ptr (with wrap).
module arb_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((int'(rr_ptr) + i) % N_REQ);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter with one-cycle response routing; fixed priority by default,
// round-robin when DMEM_ARB_RR_EN is defined.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*32-1:0]     req_wrdata,
  input  logic [N_REQ*4-1:0]      req_wrstb,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [31:0]             rsp_rddata,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wrdata,
  output logic [3:0]              mem_wrstb,
  input  logic [31:0]             mem_rddata
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] owner;
  logic [PTR_W-1:0] rr_ptr;
  mem_req_t         win;
  u32_t             held_addr;
  u32_t             held_wrdata;
  arb_state_t       state;
  arb_state_t       state_nxt;
  logic             any_grant;

`ifdef DMEM_ARB_RR_EN
  logic [3:0]       grant4;
  logic [PTR_W-1:0] rr_nxt;

  always_comb begin
    grant4              = '0;
    grant4[N_REQ-1:0]   = grant;
    rr_nxt              = PTR_W'((onehot_idx(grant4) + 1) % N_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         rr_ptr <= '0;
    else if (any_grant) rr_ptr <= rr_nxt;
  end
`else
  assign rr_ptr = '0;
`endif

  // Requests are masked during reset so nothing is granted while rst_n is low.
  arb_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .valid  (req_valid & {N_REQ{rst_n}}),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  assign any_grant = |grant;
  assign req_ready = grant;

  always_comb begin
    win = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win.addr   = u32_t'(req_addr[i*ADDR_W +: ADDR_W]);
        win.wrdata = req_wrdata[i*32 +: 32];
        win.wrstb  = req_wrstb[i*4 +: 4];
      end
    end
  end

  // Address/data hold their last granted value when idle to avoid toggling the memory pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_addr   <= '0;
      held_wrdata <= '0;
    end else if (any_grant) begin
      held_addr   <= win.addr;
      held_wrdata <= win.wrdata;
    end
  end

  assign mem_addr   = any_grant ? win.addr   : held_addr;
  assign mem_wrdata = any_grant ? win.wrdata : held_wrdata;
  assign mem_wrstb  = win.wrstb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= grant;
    end
  end

  always_comb begin
    state_nxt = any_grant ? ARB_RESP : ARB_IDLE;
    rsp_valid = '0;
    if (state == ARB_RESP && rst_n) rsp_valid = owner;
  end

  assign rsp_rddata = mem_rddata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dmem and a response scoreboard.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_wrdata;
  logic [7:0]  req_wrstb;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rddata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wrdata;
  logic [3:0]  mem_wrstb;
  logic [31:0] mem_rddata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          port;
    logic        wr;
    logic [31:0] data;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] dm[256];
  logic [31:0] sh[256];

  dmem_arbiter #(.N_REQ(2), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wrdata (req_wrdata),
    .req_wrstb  (req_wrstb),
    .rsp_valid  (rsp_valid),
    .rsp_rddata (rsp_rddata),
    .mem_addr   (mem_addr),
    .mem_wrdata (mem_wrdata),
    .mem_wrstb  (mem_wrstb),
    .mem_rddata (mem_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dmem: registered read, byte-strobed write, read returns pre-write data.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_wrstb[b]) dm[mem_addr[9:2]][b*8 +: 8] <= mem_wrdata[b*8 +: 8];
    end
    mem_rddata <= dm[mem_addr[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req_valid[p]           = v;
    req_addr[p*32 +: 32]   = a;
    req_wrdata[p*32 +: 32] = d;
    req_wrstb[p*4 +: 4]    = s;
  endtask

  // One cycle: check response against scoreboard, check grant, record acceptance, advance.
  task automatic step(input logic [1:0] exp_ready);
    sb_t         e;
    int          p;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    #1;
    if (!rst_n) begin
      check("rst_ready", 32'(req_ready), 32'(2'b00));
      check("rst_rsp",   32'(rsp_valid), 32'(2'b00));
      check("rst_wrstb", 32'(mem_wrstb), 32'(4'h0));
      sbq.delete();
    end else begin
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(2'b01 << e.port));
        if (!e.wr) check("rsp_data", rsp_rddata, e.data);
      end else begin
        check("rsp_idle", 32'(rsp_valid), 32'(2'b00));
      end
      check("grant", 32'(req_ready), 32'(exp_ready));
      if (req_ready != 2'b00) begin
        p = req_ready[1] ? 1 : 0;
        a = req_addr[p*32 +: 32];
        s = req_wrstb[p*4 +: 4];
        d = req_wrdata[p*32 +: 32];
        e.port = p;
        e.wr   = (s != 4'h0);
        e.data = sh[a[9:2]];
        sbq.push_back(e);
        for (int b = 0; b < 4; b++) begin
          if (s[b]) sh[a[9:2]][b*8 +: 8] = d[b*8 +: 8];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    req_wrdata = '0;
    req_wrstb  = '0;

    // Reset with both ports requesting; both are writes seeding later reads.
    drive(0, 1'b1, 32'h100, 32'h0000_0100, 4'hF);
    drive(1, 1'b1, 32'h104, 32'h0000_0104, 4'hF);
    @(negedge clk);
    step(2'b00);
    step(2'b00);
    rst_n = 1'b1;
    step(2'b01);
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(2'b10);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    step(2'b00);

    // Full-word write then read-back on port 0.
    drive(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    #1;
    check("wr_mem_addr",  32'(mem_addr[9:0]), 32'h10);
    check("wr_mem_data",  mem_wrdata, 32'hDEAD_BEEF);
    check("wr_mem_wrstb", 32'(mem_wrstb), 32'hF);
    step(2'b01);
    drive(0, 1'b1, 32'h10, 32'h0, 4'h0);
    step(2'b01);
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("rd_deadbeef", rsp_rddata, 32'hDEAD_BEEF);
    check("idle_hold_addr", 32'(mem_addr[9:0]), 32'h10);
    check("idle_wrstb", 32'(mem_wrstb), 32'h0);
    step(2'b00);

    // Contention for six cycles from a fresh arbitration state.
    rst_n = 1'b0;
    step(2'b00);
    rst_n = 1'b1;
    drive(0, 1'b1, 32'h100, 32'h0, 4'h0);
    drive(1, 1'b1, 32'h104, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_RR_EN
      step((i % 2 == 0) ? 2'b01 : 2'b10);
`else
      step(2'b01);
`endif
    end
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    step(2'b00);

    // Byte-lane write on port 1 over a known word.
    drive(1, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
    step(2'b10);
    drive(1, 1'b1, 32'h20, 32'h0000_AB00, 4'b0010);
    step(2'b10);
    drive(1, 1'b1, 32'h20, 32'h0, 4'h0);
    step(2'b10);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("byte_rsp_port", 32'(rsp_valid), 32'(2'b10));
    check("byte_rd_data", rsp_rddata, 32'h1122_AB44);
    step(2'b00);

    // Back-to-back writes then reads on port 0: no bubbles expected.
    drive(0, 1'b1, 32'h0, 32'hA000_0000, 4'hF);
    step(2'b01);
    drive(0, 1'b1, 32'h4, 32'hA000_0004, 4'hF);
    step(2'b01);
    drive(0, 1'b1, 32'h8, 32'hA000_0008, 4'hF);
    step(2'b01);
    drive(0, 1'b1, 32'h0, 32'h0, 4'h0);
    step(2'b01);
    drive(0, 1'b1, 32'h4, 32'h0, 4'h0);
    step(2'b01);
    drive(0, 1'b1, 32'h8, 32'h0, 4'h0);
    step(2'b01);
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("b2b_last_data", rsp_rddata, 32'hA000_0008);
    step(2'b00);

    // Reset arrives the cycle after a read grant; the pending response must vanish.
    drive(0, 1'b1, 32'h10, 32'h0, 4'h0);
    step(2'b01);
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b0;
    step(2'b00);
    step(2'b00);
    rst_n = 1'b1;
    step(2'b00);
    step(2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
